xps2_rx: RTL and testbench
==========================

XPS2_RX -- requirements
Module: xps2_rx

Interface
REQ-001 The block SHALL have parameter FIFO_AW, default 2, meaning log2 of receive FIFO depth (4 bytes).
REQ-002 The block SHALL have parameter TIMEOUT, default 5000, meaning the number of clk cycles without a PS/2 falling edge after which a partial frame is aborted.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port sel, input, 1 bit: data-bus select from the address decoder.
REQ-006 The block SHALL have port we, input, 1 bit: data-bus write enable.
REQ-007 The block SHALL have port addr, input, 1 bit: register select (0 = DATA, 1 = STATUS).
REQ-008 The block SHALL have port data_in, input, `DATA_W bits: write data.
REQ-009 The block SHALL have port data_out, output, `DATA_W bits: read data.
REQ-010 The block SHALL have port ps2_clk, input, 1 bit: asynchronous PS/2 clock from the keyboard.
REQ-011 The block SHALL have port ps2_data, input, 1 bit: asynchronous PS/2 data from the keyboard.

Function
REQ-012 The block SHALL synchronise ps2_clk and ps2_data through 2 flops each, then detect a PS/2 falling edge as the synchronised clock going from 1 in the previous cycle to 0 in the current cycle.
REQ-013 The FSM SHALL have states IDLE, DATA, PARITY and STOP, and SHALL sample ps2_data only on a detected falling edge.
REQ-014 In IDLE, a sampled 0 (start bit) SHALL move the FSM to DATA and a sampled 1 SHALL leave it in IDLE.
REQ-015 DATA SHALL shift in 8 bits, LSB first, using a 3-bit bit counter, and move to PARITY after bit 7.
REQ-016 PARITY SHALL capture the parity bit and move to STOP.
REQ-017 STOP SHALL always return to IDLE.
REQ-018 In STOP, the frame SHALL be accepted only if the stop bit is 1 and the parity check passes (see REQ-033/034).
REQ-019 If the stop bit is 0, the frame SHALL be discarded and the sticky frame_err flag set.
REQ-020 An accepted frame SHALL be pushed into the FIFO in the same cycle as the stop-bit sample.
REQ-021 A timeout counter SHALL reset on every falling edge and while in IDLE; reaching TIMEOUT in any other state SHALL return the FSM to IDLE, discard the partial frame, and leave all flags unchanged.
REQ-022 The FIFO SHALL hold 2^FIFO_AW bytes, with wrap-around read/write pointers and an occupancy count of FIFO_AW+1 bits.
REQ-023 A push while full, with no pop in the same cycle, SHALL drop the byte and set the sticky overflow flag.
REQ-024 Reading DATA (sel=1, we=0, addr=0) SHALL return {zeros, head byte} combinationally and pop the FIFO at the clock edge.
REQ-025 A DATA read while the FIFO is empty SHALL return 0 and leave the pointers unchanged.
REQ-026 A push and a pop in the same cycle SHALL both take effect, leaving the count unchanged; when full this SHALL not set overflow; when empty only the push SHALL occur.
REQ-027 Reading STATUS (addr=1) SHALL return {zeros, count[FIFO_AW:0] at bits 8 and up, 4'b0, frame_err[3], parity_err[2], overflow[1], ~empty[0]}.
REQ-028 A STATUS read SHALL have no side effects.
REQ-029 Writing STATUS with data_in[0]=1 SHALL clear all three sticky flags; a flag set in the same cycle as the clear SHALL win.
REQ-030 A write to DATA SHALL be ignored.
REQ-031 data_out SHALL be 0 whenever sel=0.

Reset
REQ-032 While rst=1, the FSM SHALL be IDLE, the bit counter, timeout counter, FIFO pointers, count and all flags SHALL be 0, and the synchroniser flops SHALL be 1 (bus idle); data_out SHALL therefore read 0, and STATUS SHALL read 0. Reset mid-frame SHALL discard the partial frame.

Configuration
REQ-033 With PS2_PARITY_CHECK_EN defined, a frame SHALL be accepted only if its 8 data bits plus the parity bit have odd parity; otherwise it SHALL be discarded and parity_err set.
REQ-034 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored, and parity_err SHALL read constant 0.

Verification
REQ-035 Frame 0x1C with correct parity (start 0, bits LSB first, parity 0, stop 1) -> STATUS=0x101, DATA read=0x1C, then STATUS=0x000.
REQ-036 Frame 0x1C with parity 1, PS2_PARITY_CHECK_EN defined -> FIFO empty, STATUS=0x004; without the macro -> byte 0x1C stored.
REQ-037 Five frames 0x11..0x15 with no reads -> STATUS=0x403, reads return 0x11,0x12,0x13,0x14; STATUS write 0x1 -> STATUS=0x000.
REQ-038 Start plus 4 data bits, then a TIMEOUT-cycle stall, then a full frame 0x5A -> only 0x5A in the FIFO, no flags set.
REQ-039 Stop bit 0 on frame 0x29 -> nothing pushed, STATUS=0x008; DATA read on the empty FIFO -> 0x0, count stays 0.
REQ-040 With the FIFO full, a DATA pop in the same cycle as a frame push -> count stays 4, overflow 0; rst asserted mid-frame -> STATUS=0, and the next full frame is received correctly.

Source files
------------

// File: rtl/xps2_rx.sv
// PS/2 keyboard receiver: 11-bit frame deserialiser feeding a small byte FIFO behind a DATA/STATUS register pair.
// Optional odd-parity checking is enabled by defining PS2_PARITY_CHECK_EN.
`ifndef DATA_W
`define DATA_W 16
`endif

module xps2_rx #(
   parameter int FIFO_AW = 2,
   parameter int TIMEOUT = 5000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sel,
   input  logic               we,
   input  logic               addr,
   input  logic [`DATA_W-1:0] data_in,
   output logic [`DATA_W-1:0] data_out,
   input  logic               ps2_clk,
   input  logic               ps2_data
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t state_reg, state_next;

   logic ps2_clk_meta_reg, ps2_clk_sync_reg, ps2_clk_prev_reg;
   logic ps2_data_meta_reg, ps2_data_sync_reg;
   logic fall;

   logic [2:0]      bit_cnt_reg, bit_cnt_next;
   logic [7:0]      shift_reg, shift_next;
   logic            parity_reg, parity_next;
   logic [TO_W-1:0] timeout_cnt_reg, timeout_cnt_next;
   logic            push_req, set_frame_err, set_parity_err;
   logic            parity_ok;

   logic [7:0]         mem [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [FIFO_AW:0]   count_reg;
   logic               full, empty, pop, do_push, set_overflow, clear_flags;
   logic               frame_err_reg, overflow_reg, parity_err;

   logic unused_data_in;
   assign unused_data_in = ^data_in[`DATA_W-1:1];

   // Synchronisers idle high so reset never fakes a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ps2_clk_meta_reg  <= 1'b1;
         ps2_clk_sync_reg  <= 1'b1;
         ps2_clk_prev_reg  <= 1'b1;
         ps2_data_meta_reg <= 1'b1;
         ps2_data_sync_reg <= 1'b1;
      end else begin
         ps2_clk_meta_reg  <= ps2_clk;
         ps2_clk_sync_reg  <= ps2_clk_meta_reg;
         ps2_clk_prev_reg  <= ps2_clk_sync_reg;
         ps2_data_meta_reg <= ps2_data;
         ps2_data_sync_reg <= ps2_data_meta_reg;
      end
   end

   assign fall = ps2_clk_prev_reg & ~ps2_clk_sync_reg;

`ifdef PS2_PARITY_CHECK_EN
   assign parity_ok = ^{shift_reg, parity_reg};
`else
   logic unused_parity;
   assign unused_parity = parity_reg;
   assign parity_ok     = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         bit_cnt_reg     <= '0;
         shift_reg       <= '0;
         parity_reg      <= 1'b0;
         timeout_cnt_reg <= '0;
      end else begin
         state_reg       <= state_next;
         bit_cnt_reg     <= bit_cnt_next;
         shift_reg       <= shift_next;
         parity_reg      <= parity_next;
         timeout_cnt_reg <= timeout_cnt_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      bit_cnt_next     = bit_cnt_reg;
      shift_next       = shift_reg;
      parity_next      = parity_reg;
      push_req         = 1'b0;
      set_frame_err    = 1'b0;
      set_parity_err   = 1'b0;
      timeout_cnt_next = (state_reg == IDLE || fall) ? '0 : timeout_cnt_reg + 1'b1;

      if (state_reg != IDLE && !fall && timeout_cnt_reg >= TO_W'(TIMEOUT)) begin
         // Stalled partial frame: drop it silently, flags untouched.
         state_next       = IDLE;
         bit_cnt_next     = '0;
         timeout_cnt_next = '0;
      end else if (fall) begin
         case (state_reg)
            IDLE: begin
               if (!ps2_data_sync_reg) begin
                  state_next   = DATA;
                  bit_cnt_next = '0;
               end
            end
            DATA: begin
               shift_next   = {ps2_data_sync_reg, shift_reg[7:1]};
               bit_cnt_next = bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7)
                  state_next = PARITY;
            end
            PARITY: begin
               parity_next = ps2_data_sync_reg;
               state_next  = STOP;
            end
            STOP: begin
               state_next = IDLE;
               if (!ps2_data_sync_reg)
                  set_frame_err = 1'b1;
               else if (parity_ok)
                  push_req = 1'b1;
               else
                  set_parity_err = 1'b1;
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign full         = (count_reg == (FIFO_AW+1)'(DEPTH));
   assign empty        = (count_reg == '0);
   assign pop          = sel & ~we & ~addr & ~empty;
   assign do_push      = push_req & (~full | pop);
   assign set_overflow = push_req & full & ~pop;
   assign clear_flags  = sel & we & addr & data_in[0];

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr_reg] <= shift_reg;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Sticky flags: a set in the same cycle as a clear takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_err_reg <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         frame_err_reg <= set_frame_err ? 1'b1 : (clear_flags ? 1'b0 : frame_err_reg);
         overflow_reg  <= set_overflow  ? 1'b1 : (clear_flags ? 1'b0 : overflow_reg);
      end
   end

`ifdef PS2_PARITY_CHECK_EN
   logic parity_err_reg;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         parity_err_reg <= 1'b0;
      else
         parity_err_reg <= set_parity_err ? 1'b1 : (clear_flags ? 1'b0 : parity_err_reg);
   end
   assign parity_err = parity_err_reg;
`else
   logic unused_set_parity_err;
   assign unused_set_parity_err = set_parity_err;
   assign parity_err            = 1'b0;
`endif

   always_comb begin
      data_out = '0;
      if (sel && !we) begin
         if (!addr) begin
            if (!empty)
               data_out[7:0] = mem[rd_ptr_reg];
         end else begin
            data_out[8 +: FIFO_AW+1] = count_reg;
            data_out[3]              = frame_err_reg;
            data_out[2]              = parity_err;
            data_out[1]              = overflow_reg;
            data_out[0]              = ~empty;
         end
      end
   end

endmodule

// File: tb/tb_xps2_rx.sv
// Directed bench for xps2_rx: table of single-frame cases plus hand-written FIFO, timeout and reset sequences.
`ifndef DATA_W
`define DATA_W 16
`endif

module tb_xps2_rx;

   localparam int FIFO_AW = 2;
   localparam int TIMEOUT = 200;
   localparam int H       = 10;

   logic               clk = 1'b0;
   logic               rst;
   logic               sel, we, addr;
   logic [`DATA_W-1:0] data_in;
   logic [`DATA_W-1:0] data_out;
   logic               ps2_clk, ps2_data;

   int n_cmp  = 0;
   int n_fail = 0;

   xps2_rx #(.FIFO_AW(FIFO_AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
      .data_in(data_in), .data_out(data_out),
      .ps2_clk(ps2_clk), .ps2_data(ps2_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  d;
      logic        bad_par;
      logic        stop;
      logic [15:0] exp_st;
      logic [15:0] exp_rd;
      logic [15:0] exp_st2;
   } vec_t;

   vec_t vecs[6];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%04h", name, act);
      end
   endtask

   task automatic read_reg(input logic a, output logic [15:0] v);
      sel = 1'b1; we = 1'b0; addr = a;
      @(negedge clk);
      v = data_out[15:0];
      tick(1);
      sel = 1'b0;
   endtask

   task automatic write_reg(input logic a, input logic [15:0] d);
      sel = 1'b1; we = 1'b1; addr = a; data_in = d;
      tick(1);
      sel = 1'b0; we = 1'b0; data_in = '0;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      tick(H);
      ps2_clk = 1'b0;
      tick(H);
      ps2_clk = 1'b1;
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic bad_par, input logic stop);
      logic par;
      par = ~(^d) ^ bad_par;
      return {stop, par, d, 1'b0};
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop, input int nbits);
      logic [10:0] fb;
      fb = frame_bits(d, bad_par, stop);
      for (int i = 0; i < nbits; i++)
         send_bit(fb[i]);
      ps2_data = 1'b1;
      tick(H);
   endtask

   // Pops DATA exactly in the cycle the stop-bit edge is acted on:
   // two synchroniser flops plus the edge-detect flop put it on the third clock.
   task automatic send_frame_pop(input logic [7:0] d, output logic [15:0] popped);
      logic [10:0] fb;
      fb = frame_bits(d, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++)
         send_bit(fb[i]);
      ps2_data = 1'b1;
      tick(H);
      ps2_clk = 1'b0;
      tick(2);
      sel = 1'b1; we = 1'b0; addr = 1'b0;
      @(negedge clk);
      popped = data_out[15:0];
      tick(1);
      sel = 1'b0;
      tick(H - 3);
      ps2_clk = 1'b1;
      tick(H);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] v;

      vecs[0] = '{8'h1C, 1'b0, 1'b1, 16'h0101, 16'h001C, 16'h0000};
      vecs[1] = '{8'h5A, 1'b0, 1'b1, 16'h0101, 16'h005A, 16'h0000};
      vecs[2] = '{8'h29, 1'b0, 1'b0, 16'h0008, 16'h0000, 16'h0008};
`ifdef PS2_PARITY_CHECK_EN
      vecs[3] = '{8'h1C, 1'b1, 1'b1, 16'h0004, 16'h0000, 16'h0004};
`else
      vecs[3] = '{8'h1C, 1'b1, 1'b1, 16'h0101, 16'h001C, 16'h0000};
`endif
      vecs[4] = '{8'hFF, 1'b0, 1'b1, 16'h0101, 16'h00FF, 16'h0000};
      vecs[5] = '{8'h00, 1'b0, 1'b1, 16'h0101, 16'h0000, 16'h0000};

      rst = 1'b1; sel = 1'b0; we = 1'b0; addr = 1'b0; data_in = '0;
      ps2_clk = 1'b1; ps2_data = 1'b1;
      tick(3);
      read_reg(1'b1, v);
      check("reset_status", v, 16'h0000);
      read_reg(1'b0, v);
      check("reset_data", v, 16'h0000);
      rst = 1'b0;
      tick(3);

      for (int i = 0; i < 6; i++) begin
         send_frame(vecs[i].d, vecs[i].bad_par, vecs[i].stop, 11);
         read_reg(1'b1, v);
         check($sformatf("vec%0d_status", i), v, vecs[i].exp_st);
         read_reg(1'b0, v);
         check($sformatf("vec%0d_data", i), v, vecs[i].exp_rd);
         read_reg(1'b1, v);
         check($sformatf("vec%0d_status_after", i), v, vecs[i].exp_st2);
         write_reg(1'b1, 16'h0001);
         read_reg(1'b1, v);
         check($sformatf("vec%0d_cleared", i), v, 16'h0000);
      end

      // Overflow: five frames into a four-deep FIFO.
      for (int i = 0; i < 5; i++)
         send_frame(8'h11 + 8'(i), 1'b0, 1'b1, 11);
      read_reg(1'b1, v);
      check("ovf_status", v, 16'h0403);
      for (int i = 0; i < 4; i++) begin
         read_reg(1'b0, v);
         check($sformatf("ovf_read%0d", i), v, 16'h0011 + 16'(i));
      end
      read_reg(1'b1, v);
      check("ovf_status_drained", v, 16'h0002);
      write_reg(1'b1, 16'h0001);
      read_reg(1'b1, v);
      check("ovf_cleared", v, 16'h0000);

      // Timeout: partial frame, stall, then a clean frame.
      send_frame(8'hA5, 1'b0, 1'b1, 5);
      tick(TIMEOUT + 50);
      send_frame(8'h5A, 1'b0, 1'b1, 11);
      read_reg(1'b1, v);
      check("tmo_status", v, 16'h0101);
      sel = 1'b0; we = 1'b0; addr = 1'b0;
      @(negedge clk);
      check("tmo_unselected_out", data_out[15:0], 16'h0000);
      tick(1);
      read_reg(1'b0, v);
      check("tmo_data", v, 16'h005A);
      read_reg(1'b1, v);
      check("tmo_status_after", v, 16'h0000);

      // Full FIFO with a pop landing on the push cycle.
      for (int i = 0; i < 4; i++)
         send_frame(8'h21 + 8'(i), 1'b0, 1'b1, 11);
      read_reg(1'b1, v);
      check("full_status", v, 16'h0401);
      send_frame_pop(8'h25, v);
      check("full_popped", v, 16'h0021);
      read_reg(1'b1, v);
      check("full_status_after", v, 16'h0401);
      for (int i = 0; i < 4; i++) begin
         read_reg(1'b0, v);
         check($sformatf("full_read%0d", i), v, 16'h0022 + 16'(i));
      end
      read_reg(1'b1, v);
      check("full_status_drained", v, 16'h0000);

      // Reset in the middle of a frame, then a good frame.
      send_frame(8'hC3, 1'b0, 1'b1, 4);
      rst = 1'b1;
      tick(1);
      read_reg(1'b1, v);
      check("rst_mid_status", v, 16'h0000);
      rst = 1'b0;
      tick(2);
      send_frame(8'h3C, 1'b0, 1'b1, 11);
      read_reg(1'b1, v);
      check("rst_next_status", v, 16'h0101);
      write_reg(1'b0, 16'h00AB);
      read_reg(1'b1, v);
      check("data_write_ignored", v, 16'h0101);
      read_reg(1'b0, v);
      check("rst_next_data", v, 16'h003C);
      read_reg(1'b0, v);
      check("empty_read", v, 16'h0000);
      read_reg(1'b1, v);
      check("empty_status", v, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
